div_radix2: RTL and testbench
=============================

Name: div_radix2

Overview:
- Multi-cycle restoring radix-2 integer divider for the execute stage.
- Acts as the responder to the ALU top's mul/div start/ready handshake: the issuer holds start_i with latched operands until ready_o pulses, then writes result_o into HI/LO that cycle.
- Supports MIPS DIV/DIVU. result_o = {remainder, quotient} so it maps directly onto {HI, LO}.

Parameters:
WIDTH, 32, operand width; result is 2*WIDTH

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
flush  input  1  pipeline flush of the issuing slot; aborts any operation
annul_i  input  1  software cancel; same effect as flush
start_i  input  1  request; sampled only in IDLE
signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i
opdata1_i  input  WIDTH  dividend; sampled with start_i
opdata2_i  input  WIDTH  divisor; sampled with start_i
ready_o  output  1  one-cycle completion pulse; result_o valid in this cycle
result_o  output  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}

Behaviour:
- Reset (async, any state): state=IDLE, ready_o=0, result_o=0, counter=0, internal dividend/divisor/partial-remainder regs=0.
- States are IDLE, DIVZERO, BUSY and DONE.
- IDLE:
  - start_i & ~flush & ~annul_i & opdata2_i==0 -> DIVZERO.
  - start_i & ~flush & ~annul_i & opdata2_i!=0 -> BUSY; latch |opdata1_i|, |opdata2_i| (absolute values only when signed_div_i=1), quotient sign = a[W-1]^b[W-1], remainder sign = a[W-1] (signed only), counter=0.
  - Otherwise stay in IDLE.
- BUSY:
  - One quotient bit per cycle, MSB first: shift {rem, dvd} left 1, trial subtract divisor, keep if non-negative, set quotient bit.
  - counter increments; after WIDTH iterations -> DONE, and result_o registers the sign-corrected {rem, quo}.
- DIVZERO: one cycle -> DONE with result_o = 0 (architecturally UNPREDICTABLE; fixed here for determinism).
- DONE:
  - ready_o=1 for exactly this one cycle, then -> IDLE unconditionally.
  - start_i is not re-sampled in DONE, so the issuer dropping start combinationally on ready is safe.
- ready_o is a registered state decode and is 0 in every state except DONE.
- result_o holds its last value until the next completion. Operand changes after the sample cycle are ignored.
- Latency: start sampled at edge 0 -> ready_o high in cycle WIDTH+1 (33 for WIDTH=32). Divide-by-zero: ready_o high in cycle 2.
- flush or annul_i in DIVZERO/BUSY/DONE: next state IDLE, ready_o=0 from the next cycle, result_o unchanged.
  - flush in the same cycle as start_i in IDLE: start is ignored.
  - flush while in DONE: the pulse visible this cycle still occurs (the issuer gates the HI/LO write).
- Signed edge cases:
  - Sign correction is two's-complement negate, truncated to WIDTH.
  - 0x80000000 / 0xFFFFFFFF gives quo 0x80000000, rem 0 (wrap, no trap).
  - |0x80000000| is represented as unsigned 0x80000000.
- start_i asserted while BUSY/DIVZERO/DONE: ignored; no queueing.

Test Plan:
- Unsigned 100/7 (signed_div_i=0, start held until ready) -> ready_o at cycle 33, result_o=64'h00000002_0000000E, ready_o low at cycle 34.
- Signed -7/2 (0xFFFFFFF9, 0x00000002) -> result_o=64'hFFFFFFFF_FFFFFFFD. Signed 7/-2 -> 64'h00000001_FFFFFFFD.
- 0x80000000 / 0xFFFFFFFF:
  - Signed -> 64'h00000000_80000000.
  - Unsigned -> 64'h80000000_00000000.
- Divisor 0 (any dividend) -> ready_o at cycle 2, result_o=0. A following 9/3 op -> 64'h00000000_00000003.
- flush pulse at cycle 10 of a 100/7 op -> no ready_o through cycle 40, result_o unchanged. A new start afterwards completes correctly 33 cycles later.
- rst asserted asynchronously mid-BUSY (between edges) -> ready_o=0 and result_o=0 immediately. After release, idle until start.

Source files
------------

// File: rtl/div_radix2.sv
// Multi-cycle restoring radix-2 divider for MIPS DIV/DIVU.
// result_o = {remainder, quotient}, mapping directly onto {HI, LO}.
module div_radix2 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 annul_i,
    input  logic                 start_i,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    output logic                 ready_o,
    output logic [2*WIDTH-1:0]   result_o
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIVZERO = 2'd1,
        BUSY    = 2'd2,
        DONE    = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]      dvd_q, dvd_d;
    logic [WIDTH-1:0]      dvs_q, dvs_d;
    logic [WIDTH-1:0]      rem_q, rem_d;
    logic                  neg_quo_q, neg_quo_d;
    logic                  neg_rem_q, neg_rem_d;
    logic                  ready_q, ready_d;
    logic [2*WIDTH-1:0]    result_q, result_d;

    logic                  abort;
    logic                  neg_a, neg_b;
    logic [WIDTH-1:0]      abs_a, abs_b;
    logic [WIDTH:0]        rem_sh, diff;
    logic                  ge;
    logic [WIDTH-1:0]      rem_nxt, quo_nxt;
    logic [WIDTH-1:0]      rem_fix, quo_fix;

    // Operand magnitudes; |most-negative| naturally wraps to the same unsigned pattern.
    always_comb begin
        abort  = flush | annul_i;
        neg_a  = signed_div_i & opdata1_i[WIDTH-1];
        neg_b  = signed_div_i & opdata2_i[WIDTH-1];
        abs_a  = neg_a ? (WIDTH'(0) - opdata1_i) : opdata1_i;
        abs_b  = neg_b ? (WIDTH'(0) - opdata2_i) : opdata2_i;
    end

    // One restoring step: shifted remainder is < 2*divisor, so WIDTH+1 bits suffice.
    always_comb begin
        rem_sh  = {rem_q, dvd_q[WIDTH-1]};
        diff    = rem_sh - {1'b0, dvs_q};
        ge      = ~diff[WIDTH];
        rem_nxt = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_nxt = {dvd_q[WIDTH-2:0], ge};
        quo_fix = neg_quo_q ? (WIDTH'(0) - quo_nxt) : quo_nxt;
        rem_fix = neg_rem_q ? (WIDTH'(0) - rem_nxt) : rem_nxt;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        ready_d   = 1'b0;
        result_d  = result_q;

        case (state_q)
            IDLE: begin
                if (start_i && !abort) begin
                    if (opdata2_i == '0) begin
                        state_d = DIVZERO;
                    end else begin
                        state_d   = BUSY;
                        dvd_d     = abs_a;
                        dvs_d     = abs_b;
                        rem_d     = '0;
                        cnt_d     = '0;
                        neg_quo_d = neg_a ^ neg_b;
                        neg_rem_d = neg_a;
                    end
                end
            end
            DIVZERO: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    state_d  = DONE;
                    ready_d  = 1'b1;
                    result_d = '0;
                end
            end
            BUSY: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    rem_d = rem_nxt;
                    dvd_d = quo_nxt;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d  = DONE;
                        ready_d  = 1'b1;
                        result_d = {rem_fix, quo_fix};
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            ready_q   <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            ready_q   <= ready_d;
            result_q  <= result_d;
        end
    end

    assign ready_o  = ready_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_div_radix2.sv
// Directed bench for div_radix2 with a cycle-level arithmetic reference model.
module tb_div_radix2;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        annul_i;
    logic        start_i;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        ready_o;
    logic [63:0] result_o;

    int checks   = 0;
    int failures = 0;

    div_radix2 #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .annul_i      (annul_i),
        .start_i      (start_i),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .ready_o      (ready_o),
        .result_o     (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural result: C-style truncating division, remainder takes the dividend's sign.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counts cycles to completion per accepted request.
    logic        m_busy = 1'b0;
    int          m_left = 0;
    logic [63:0] m_pend = 64'd0;
    logic        exp_ready = 1'b0;
    logic [63:0] exp_result = 64'd0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy     = 1'b0;
            m_left     = 0;
            exp_ready  = 1'b0;
            exp_result = 64'd0;
        end else if (exp_ready) begin
            exp_ready = 1'b0;
            m_busy    = 1'b0;
        end else if (m_busy) begin
            if (flush || annul_i) begin
                m_busy = 1'b0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    exp_ready  = 1'b1;
                    exp_result = m_pend;
                end
            end
        end else if (start_i && !flush && !annul_i) begin
            m_busy = 1'b1;
            m_left = (opdata2_i == 32'd0) ? 1 : 32;
            m_pend = ref_div(opdata1_i, opdata2_i, signed_div_i);
        end
        #1;
        check("model_ready", {63'd0, ready_o}, {63'd0, exp_ready});
        check("model_result", result_o, exp_result);
    end

    // Issue and hold start until ready; cycle 1 is the cycle ending with the sampling edge.
    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [63:0] lit, input int exp_cyc);
        int n;
        n = 0;
        @(negedge clk);
        start_i      = 1'b1;
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        while (1) begin
            @(posedge clk);
            #1;
            n++;
            if (ready_o) break;
            if (n > 100) break;
        end
        check({name, "_latency"}, 64'(n), 64'(exp_cyc));
        check({name, "_result"}, result_o, lit);
        @(negedge clk);
        start_i   = 1'b0;
        opdata1_i = 32'hDEAD_BEEF;
        opdata2_i = 32'h0;
        @(posedge clk);
        #1;
        check({name, "_ready_drop"}, {63'd0, ready_o}, 64'd0);
    endtask

    task automatic no_ready(input string name, input int cycles);
        logic seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (ready_o) seen = 1'b1;
        end
        check(name, {63'd0, seen}, 64'd0);
    endtask

    // Single-cycle start pulse, then an abort on 'abort_cyc' via flush (sel=0) or annul (sel=1).
    task automatic aborted_op(input logic [31:0] a, input logic [31:0] b, input int abort_cyc,
                              input logic sel);
        @(negedge clk);
        start_i      = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = a;
        opdata2_i    = b;
        @(negedge clk);
        start_i = 1'b0;
        repeat (abort_cyc - 1) @(negedge clk);
        if (sel) annul_i = 1'b1;
        else     flush   = 1'b1;
        @(negedge clk);
        flush   = 1'b0;
        annul_i = 1'b0;
    endtask

    logic [63:0] saved;

    initial begin
        rst          = 1'b1;
        flush        = 1'b0;
        annul_i      = 1'b0;
        start_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        #1;
        check("reset_ready", {63'd0, ready_o}, 64'd0);
        check("reset_result", result_o, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        no_ready("idle_after_reset", 3);

        // Pin the reference model itself.
        check("ref_100_7", ref_div(32'd100, 32'd7, 1'b0), 64'h00000002_0000000E);
        check("ref_min_m1_s", ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1), 64'h00000000_80000000);
        check("ref_m7_2", ref_div(32'hFFFF_FFF9, 32'd2, 1'b1), 64'hFFFFFFFF_FFFFFFFD);

        run_op("u_100_7", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33);
        run_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 33);
        run_op("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 64'h00000001_FFFFFFFD, 33);
        run_op("s_m100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 64'hFFFFFFFE_0000000E, 33);
        run_op("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h00000000_80000000, 33);
        run_op("u_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 64'h80000000_00000000, 33);
        run_op("u_big", 32'd123456789, 32'd1000, 1'b0, 64'h00000315_0001E240, 33);
        run_op("u_small_big", 32'd5, 32'h8000_0000, 1'b0, 64'h00000005_00000000, 33);
        run_op("div_zero", 32'd1234, 32'd0, 1'b1, 64'd0, 2);
        run_op("u_9_3", 32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 33);

        // Flush mid-operation: no completion, result held.
        saved = result_o;
        aborted_op(32'd100, 32'd7, 10, 1'b0);
        no_ready("flush_no_ready", 30);
        check("flush_result_held", result_o, 64'h00000000_00000003);
        run_op("after_flush", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33);

        // Annul mid-operation behaves like flush.
        aborted_op(32'd1000, 32'd10, 5, 1'b1);
        no_ready("annul_no_ready", 35);
        check("annul_result_held", result_o, 64'h00000002_0000000E);

        // Start coinciding with flush in IDLE is dropped.
        @(negedge clk);
        start_i   = 1'b1;
        flush     = 1'b1;
        opdata1_i = 32'd50;
        opdata2_i = 32'd5;
        @(negedge clk);
        start_i = 1'b0;
        flush   = 1'b0;
        no_ready("start_with_flush", 40);

        // Asynchronous reset between edges during BUSY.
        @(negedge clk);
        start_i   = 1'b1;
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        @(negedge clk);
        start_i = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_ready", {63'd0, ready_o}, 64'd0);
        check("async_rst_result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        no_ready("idle_after_async_rst", 40);
        check("idle_result_zero", result_o, 64'd0);
        run_op("after_rst", 32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 33);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
